// File: rtl/sha256_pkg.sv
// Shared definitions for the SHA-256 message padder: FSM states and
// block/padding constants.
package sha256_pkg;

  localparam int         BLOCK_BYTES = 64;
  localparam int         LEN_SLOT    = 56;
  localparam logic [7:0] PAD_BYTE    = 8'h80;

  typedef enum logic [2:0] {
    ST_FILL,
    ST_PAD80,
    ST_ZERO,
    ST_LEN,
    ST_ISSUE,
    ST_WAIT,
    ST_DONE
  } state_t;

endpackage

// File: rtl/sha256_block_buf.sv
// 512-bit block buffer for the SHA-256 padder. Each cycle it can write
// either one byte slot, or the whole 64-bit big-endian length field in
// slots 56..63. Byte slot 0 appears at o_data[511:504].
module sha256_block_buf
  import sha256_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_byte_we,
  input  logic [5:0]   i_byte_idx,
  input  logic [7:0]   i_byte_data,
  input  logic         i_len_we,
  input  logic [63:0]  i_len,
  output logic [511:0] o_data
);

  logic [7:0] r_bytes [BLOCK_BYTES];

  // Slot storage. The length write takes priority; the FSM never
  // requests both writes in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < BLOCK_BYTES; i++) begin
        r_bytes[i] <= '0;
      end
    end else if (i_len_we) begin
      for (int i = 0; i < 8; i++) begin
        r_bytes[LEN_SLOT + i] <= i_len[63 - 8*i -: 8];
      end
    end else if (i_byte_we) begin
      r_bytes[i_byte_idx] <= i_byte_data;
    end
  end

  // Flatten the slots so byte 0 is the most significant byte.
  always_comb begin
    o_data = '0;
    for (int i = 0; i < BLOCK_BYTES; i++) begin
      o_data[511 - 8*i -: 8] = r_bytes[i];
    end
  end

endmodule

// File: rtl/sha256_msg_padder.sv
// SHA-256 message padder. Packs an input byte stream into 512-bit blocks,
// appends 0x80, zero fill and the 64-bit bit length, and hands each block
// to the compression core with a start pulse, waiting for the core's ready.
module sha256_msg_padder
  import sha256_pkg::*;
#(
  parameter int LEN_W = 64
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [7:0]   in_data,
  input  logic         in_valid,
  input  logic         in_last,
  output logic         in_ready,
  output logic [511:0] blk_data,
  output logic         blk_start,
  output logic         blk_first,
  input  logic         core_ready,
  output logic         msg_done,
  output logic         busy
);

  localparam logic [5:0] PTR_LAST   = 6'(BLOCK_BYTES - 1);
  localparam logic [5:0] PTR_PRELEN = 6'(LEN_SLOT - 1);

  state_t           r_state;
  logic [5:0]       r_ptr;
  logic [LEN_W-1:0] r_bitlen;
  logic             r_first;
  logic             r_last_seen;
  logic             r_pad80_done;
  logic             r_final;

  state_t           w_state_nxt;
  logic [5:0]       w_ptr_nxt;
  logic [LEN_W-1:0] w_bitlen_nxt;
  logic             w_first_nxt;
  logic             w_last_seen_nxt;
  logic             w_pad80_done_nxt;
  logic             w_final_nxt;
  logic             w_byte_we;
  logic [7:0]       w_byte_data;
  logic             w_len_we;
  logic [63:0]      w_len64;

  assign w_len64 = 64'(r_bitlen);

  sha256_block_buf u_buf (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_byte_we   (w_byte_we),
    .i_byte_idx  (r_ptr),
    .i_byte_data (w_byte_data),
    .i_len_we    (w_len_we),
    .i_len       (w_len64),
    .o_data      (blk_data)
  );

  // State register and control flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_FILL;
      r_ptr        <= '0;
      r_bitlen     <= '0;
      r_first      <= 1'b1;
      r_last_seen  <= 1'b0;
      r_pad80_done <= 1'b0;
      r_final      <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_ptr        <= w_ptr_nxt;
      r_bitlen     <= w_bitlen_nxt;
      r_first      <= w_first_nxt;
      r_last_seen  <= w_last_seen_nxt;
      r_pad80_done <= w_pad80_done_nxt;
      r_final      <= w_final_nxt;
    end
  end

  // Next-state, buffer write requests and handshake outputs.
  always_comb begin
    w_state_nxt      = r_state;
    w_ptr_nxt        = r_ptr;
    w_bitlen_nxt     = r_bitlen;
    w_first_nxt      = r_first;
    w_last_seen_nxt  = r_last_seen;
    w_pad80_done_nxt = r_pad80_done;
    w_final_nxt      = r_final;
    w_byte_we        = 1'b0;
    w_byte_data      = in_data;
    w_len_we         = 1'b0;
    in_ready         = 1'b0;
    blk_start        = 1'b0;
    blk_first        = 1'b0;
    msg_done         = 1'b0;

    case (r_state)
      ST_FILL: begin
        in_ready = 1'b1;
        if (in_valid) begin
          w_byte_we    = 1'b1;
          w_byte_data  = in_data;
          w_ptr_nxt    = r_ptr + 6'd1;
          w_bitlen_nxt = r_bitlen + LEN_W'(8);
          if (r_ptr == PTR_LAST) begin
            w_state_nxt     = ST_ISSUE;
            w_last_seen_nxt = in_last;
          end else if (in_last) begin
            w_state_nxt = ST_PAD80;
          end
        end
      end

      ST_PAD80: begin
        w_byte_we        = 1'b1;
        w_byte_data      = PAD_BYTE;
        w_pad80_done_nxt = 1'b1;
        w_ptr_nxt        = r_ptr + 6'd1;
        if (r_ptr == PTR_LAST) begin
          w_state_nxt = ST_ISSUE;
        end else if (r_ptr == PTR_PRELEN) begin
          w_state_nxt = ST_LEN;
        end else begin
          w_state_nxt = ST_ZERO;
        end
      end

      ST_ZERO: begin
        w_byte_we   = 1'b1;
        w_byte_data = 8'h00;
        w_ptr_nxt   = r_ptr + 6'd1;
        if (r_ptr == PTR_PRELEN) begin
          w_state_nxt = ST_LEN;
        end else if (r_ptr == PTR_LAST) begin
          w_state_nxt = ST_ISSUE;
        end
      end

      ST_LEN: begin
        w_len_we    = 1'b1;
        w_final_nxt = 1'b1;
        w_state_nxt = ST_ISSUE;
      end

      ST_ISSUE: begin
        blk_start   = 1'b1;
        blk_first   = r_first;
        w_state_nxt = ST_WAIT;
      end

      ST_WAIT: begin
        if (core_ready) begin
          w_first_nxt = 1'b0;
          w_ptr_nxt   = '0;
          if (r_final) begin
            w_state_nxt = ST_DONE;
          end else if (r_last_seen && !r_pad80_done) begin
            w_state_nxt = ST_PAD80;
          end else if (r_pad80_done) begin
            w_state_nxt = ST_ZERO;
          end else begin
            w_state_nxt = ST_FILL;
          end
        end
      end

      ST_DONE: begin
        msg_done         = 1'b1;
        w_bitlen_nxt     = '0;
        w_first_nxt      = 1'b1;
        w_last_seen_nxt  = 1'b0;
        w_pad80_done_nxt = 1'b0;
        w_final_nxt      = 1'b0;
        w_ptr_nxt        = '0;
        w_state_nxt      = ST_FILL;
      end

      default: begin
        w_state_nxt = ST_FILL;
      end
    endcase
  end

  assign busy = !((r_state == ST_FILL) && (r_ptr == 6'd0) && r_first);

endmodule
